i_serdes_deser_param: RTL and testbench
=======================================

# i_serdes_deser_param

Parametrised 1:WIDTH input deserializer: the next-generation soft equivalent of the fixed 4-bit I_SERDES receive path. Captures one bit of `data_in` per `CLK_IN` cycle and assembles MSB-first words. Supports user bitslip, enable and PLL-lock gating, and an optional training-pattern word aligner. Sits between the pad input register and the fabric receive logic.

## Interface
Parameters:
- `WIDTH`, default 4: deserialization ratio; legal range 3..10.
- `TRAIN_PATTERN`, default 'h3 (zero-extended to WIDTH, so 4'b0011 at WIDTH=4): aligner target word.
- `LOCK_COUNT`, default 4: consecutive pattern matches required for lock; legal range 1..15.

Ports:
- `CLK_IN`, in, 1: the one clock. All logic is rising-edge.
- `RX_RST`, in, 1: reset, asynchronous, active-low.
- `EN`, in, 1: capture enable.
- `PLL_LOCK`, in, 1: PLL locked qualifier.
- `data_in`, in, 1: serial data, one bit per cycle.
- `BITSLIP_ADJ`, in, 1: bitslip request; acts on its rising edge.
- `Q`, out, WIDTH: deserialized word. The first-received bit is in `Q[WIDTH-1]`.
- `DATA_VALID`, out, 1: one-cycle strobe marking a new `Q`.
- `SLIP_CNT`, out, $clog2(WIDTH): total slips applied, modulo WIDTH.
- `ALIGN_LOCK`, out, 1: aligner locked.
- `ALIGN_ERROR`, out, 1: aligner exhausted all offsets.

## Operation
- **Active qualifier:** active = `EN` & `PLL_LOCK`. When not active:
  - the shift register, bit counter and `Q` hold;
  - `DATA_VALID` is 0.
- **Shift:** on each active cycle, sr <= {sr[WIDTH-2:0], `data_in`}. The bit counter bcnt counts 0..WIDTH-1 and wraps.
- **Word emit:** on an active cycle with bcnt==WIDTH-1, `Q` <= {sr[WIDTH-2:0], `data_in`} and `DATA_VALID` <= 1. `DATA_VALID` is 0 on all other cycles.
- **Bitslip:**
  - A BITSLIP_ADJ rising edge is detected against a registered copy of the input; that copy updates every cycle, active or not.
  - On an active cycle with a detected edge, bcnt holds instead of advancing and `SLIP_CNT` increments modulo WIDTH. Net effect: the word boundary moves one bit later.
  - If the slip lands on bcnt==WIDTH-1, that cycle's emit is suppressed and the emit occurs on the next active cycle.
  - An edge detected on an inactive cycle is dropped.
- **PLL_LOCK drop:** while `PLL_LOCK`=0, bcnt is forced to 0 and the aligner returns to HUNT. `SLIP_CNT`, sr and `Q` are retained.
- **Reset:** every output and all internal state is 0 immediately on `RX_RST`=0. The aligner starts in HUNT.
- **Aligner (I_SERDES_AUTO_ALIGN_EN only).** States are HUNT, DISCARD, LOCKED and ERROR; transitions are evaluated only on `DATA_VALID` cycles.
  - HUNT, `Q`==TRAIN_PATTERN: mcnt++. When mcnt reaches LOCK_COUNT, go to LOCKED and set `ALIGN_LOCK`=1.
  - HUNT, mismatch, tries<WIDTH: mcnt=0, tries++, issue one internal slip on the next active cycle, go to DISCARD.
  - HUNT, mismatch, tries==WIDTH: go to ERROR and set `ALIGN_ERROR`=1.
  - DISCARD: drop one word, then return to HUNT.
  - LOCKED: holds regardless of data.
  - ERROR: sticky until reset or a `PLL_LOCK` drop.
  - External bitslip edges are ignored in HUNT and DISCARD, and honoured in LOCKED and ERROR.
  - An internal slip has the same effect as an external slip, including the `SLIP_CNT` increment.

## Timing
- **Latency:** the last bit of a word is sampled at edge N; `Q` and `DATA_VALID` are valid after edge N. Latency is one cycle from the last bit's arrival to the strobe.
- **Word rate:** with no slips and EN held high, `DATA_VALID` pulses once every WIDTH cycles.
- **Slip cost:** each slip delays the next emit by exactly one active cycle.
- **First word after reset:** the first WIDTH active bits.
- **Flag timing:** `ALIGN_LOCK` and `ALIGN_ERROR` register on the edge following the deciding `DATA_VALID`.

## Configuration
- Macro `I_SERDES_AUTO_ALIGN_EN`.
- **Defined:** the aligner FSM is present and behaves as described under Operation.
- **Undefined:** the aligner is absent. `ALIGN_LOCK` and `ALIGN_ERROR` are tied to 0, and only external bitslip moves the word boundary.

## Structure
- **Package `i_serdes_pkg`:**
  - align state enum (HUNT, DISCARD, LOCKED, ERROR);
  - WIDTH_MIN=3 and WIDTH_MAX=10;
  - the LOCK_COUNT counter width.
- **Sub-module `i_serdes_align_fsm`:**
  - inputs: `Q`, `DATA_VALID`, `PLL_LOCK`;
  - outputs: slip request, `ALIGN_LOCK`, `ALIGN_ERROR`;
  - instantiated only under the macro.
- **Top:** shift register, bcnt, edge detector and output registers.

## Test plan
All scenarios use WIDTH=4.
- **Reset:** drive `RX_RST`=0 mid-stream -> `Q`=0, `DATA_VALID`=0, `SLIP_CNT`=0, `ALIGN_LOCK`=0 and `ALIGN_ERROR`=0 immediately, without waiting for a clock.
- **Basic capture:** EN=1, `PLL_LOCK`=1, stream 1,0,1,1 repeated -> `Q`=4'b1011 with `DATA_VALID` high one cycle in every 4.
- **Bitslip:** stream 1,0,0,0 repeated, `Q`=4'b1000; pulse `BITSLIP_ADJ` once -> next emit one cycle late, `Q`=4'b0001, `SLIP_CNT`=1. Four total slips -> `Q`=4'b1000 and `SLIP_CNT`=0.
- **Gating:** drop EN for 3 cycles mid-word -> no `DATA_VALID`; the word completes with the same bits once EN returns. A `PLL_LOCK` pulse low -> bcnt restarts at 0.
- **Auto-align (macro defined):** stream 0,0,1,1 repeated, phase-offset by 2 -> exactly 2 internal slips (`SLIP_CNT`=2), `Q`=4'b0011, then `ALIGN_LOCK`=1 after 4 consecutive matching words.
- **Align error (macro defined):** constant 0 stream -> 4 slips, then `ALIGN_ERROR`=1 on the next mismatch; the error clears on a `PLL_LOCK` drop.

Source files
------------

// File: rtl/i_serdes_pkg.sv
// ============================================================================
// Module   : i_serdes_pkg
// Brief    : Shared types and limits for the parametrised I_SERDES deserializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i_serdes_pkg;

   localparam int WIDTH_MIN  = 3;
   localparam int WIDTH_MAX  = 10;
   localparam int LOCK_CNT_W = 4;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      DISCARD = 2'd1,
      LOCKED  = 2'd2,
      ERROR   = 2'd3
   } align_state_t;

endpackage

`default_nettype wire

// File: rtl/i_serdes_align_fsm.sv
// ============================================================================
// Module   : i_serdes_align_fsm
// Brief    : Training-pattern word aligner; requests one slip per mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i_serdes_align_fsm
   import i_serdes_pkg::*;
#(
   parameter int               WIDTH         = 4,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = 'h3,
   parameter int               LOCK_COUNT    = 4
) (
   input  logic             CLK_IN,
   input  logic             RX_RST,
   input  logic             active,
   input  logic             PLL_LOCK,
   input  logic [WIDTH-1:0] Q,
   input  logic             DATA_VALID,
   output logic             slip_req,
   output logic             ext_allow,
   output logic             ALIGN_LOCK,
   output logic             ALIGN_ERROR
);

   localparam int TRY_W = $clog2(WIDTH + 1);

   align_state_t          r_state, w_state_nxt;
   logic [LOCK_CNT_W-1:0] r_mcnt, w_mcnt_nxt;
   logic [TRY_W-1:0]      r_tries, w_tries_nxt;
   logic                  r_slip_pend, w_slip_pend_nxt;

   always_ff @(posedge CLK_IN or negedge RX_RST) begin
      if (!RX_RST) begin
         r_state     <= HUNT;
         r_mcnt      <= '0;
         r_tries     <= '0;
         r_slip_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mcnt      <= w_mcnt_nxt;
         r_tries     <= w_tries_nxt;
         r_slip_pend <= w_slip_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_mcnt_nxt      = r_mcnt;
      w_tries_nxt     = r_tries;
      // a pending slip is consumed by the first active cycle that sees it
      w_slip_pend_nxt = r_slip_pend & ~active;
      if (!PLL_LOCK) begin
         w_state_nxt     = HUNT;
         w_mcnt_nxt      = '0;
         w_tries_nxt     = '0;
         w_slip_pend_nxt = 1'b0;
      end else if (DATA_VALID) begin
         case (r_state)
            HUNT: begin
               if (Q == TRAIN_PATTERN) begin
                  if (r_mcnt == LOCK_CNT_W'(LOCK_COUNT - 1))
                     w_state_nxt = LOCKED;
                  else
                     w_mcnt_nxt = r_mcnt + 1'b1;
               end else if (r_tries == TRY_W'(WIDTH)) begin
                  w_state_nxt = ERROR;
               end else begin
                  w_mcnt_nxt      = '0;
                  w_tries_nxt     = r_tries + 1'b1;
                  w_slip_pend_nxt = 1'b1;
                  w_state_nxt     = DISCARD;
               end
            end
            DISCARD: w_state_nxt = HUNT;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   assign slip_req    = r_slip_pend;
   assign ext_allow   = (r_state == LOCKED) || (r_state == ERROR);
   assign ALIGN_LOCK  = (r_state == LOCKED);
   assign ALIGN_ERROR = (r_state == ERROR);

endmodule

`default_nettype wire

// File: rtl/i_serdes_deser_param.sv
// ============================================================================
// Module   : i_serdes_deser_param
// Brief    : 1:WIDTH MSB-first deserializer with bitslip and gating; the
//            training aligner is built only when I_SERDES_AUTO_ALIGN_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i_serdes_deser_param
   import i_serdes_pkg::*;
#(
   parameter int               WIDTH         = 4,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = 'h3,
   parameter int               LOCK_COUNT    = 4
) (
   input  logic                     CLK_IN,
   input  logic                     RX_RST,
   input  logic                     EN,
   input  logic                     PLL_LOCK,
   input  logic                     data_in,
   input  logic                     BITSLIP_ADJ,
   output logic [WIDTH-1:0]         Q,
   output logic                     DATA_VALID,
   output logic [$clog2(WIDTH)-1:0] SLIP_CNT,
   output logic                     ALIGN_LOCK,
   output logic                     ALIGN_ERROR
);

   localparam int CNT_W = $clog2(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("i_serdes_deser_param: WIDTH out of range");
   end
   if (LOCK_COUNT < 1 || LOCK_COUNT >= (1 << LOCK_CNT_W)) begin : g_lock_check
      $error("i_serdes_deser_param: LOCK_COUNT out of range");
   end

   // only the low WIDTH-1 bits are kept; the newest bit comes straight from data_in
   logic [WIDTH-2:0] r_sr;
   logic [CNT_W-1:0] r_bcnt;
   logic [CNT_W-1:0] r_slip_cnt;
   logic [WIDTH-1:0] r_q;
   logic             r_valid;
   logic             r_bsl_d;
   logic             w_active;
   logic             w_edge;
   logic             w_slip;

   assign w_active = EN & PLL_LOCK;
   assign w_edge   = BITSLIP_ADJ & ~r_bsl_d;

`ifdef I_SERDES_AUTO_ALIGN_EN
   logic w_int_slip;
   logic w_ext_allow;

   i_serdes_align_fsm #(
      .WIDTH         (WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .LOCK_COUNT    (LOCK_COUNT)
   ) u_align_fsm (
      .CLK_IN      (CLK_IN),
      .RX_RST      (RX_RST),
      .active      (w_active),
      .PLL_LOCK    (PLL_LOCK),
      .Q           (r_q),
      .DATA_VALID  (r_valid),
      .slip_req    (w_int_slip),
      .ext_allow   (w_ext_allow),
      .ALIGN_LOCK  (ALIGN_LOCK),
      .ALIGN_ERROR (ALIGN_ERROR)
   );

   assign w_slip = w_active & ((w_edge & w_ext_allow) | w_int_slip);
`else
   assign w_slip      = w_active & w_edge;
   assign ALIGN_LOCK  = 1'b0;
   assign ALIGN_ERROR = 1'b0;
`endif

   always_ff @(posedge CLK_IN or negedge RX_RST) begin
      if (!RX_RST) begin
         r_sr       <= '0;
         r_bcnt     <= '0;
         r_slip_cnt <= '0;
         r_q        <= '0;
         r_valid    <= 1'b0;
         r_bsl_d    <= 1'b0;
      end else begin
         r_bsl_d <= BITSLIP_ADJ;
         r_valid <= 1'b0;
         if (!PLL_LOCK) begin
            r_bcnt <= '0;
         end else if (EN) begin
            r_sr <= {r_sr[WIDTH-3:0], data_in};
            // a slip freezes the bit counter, pushing the boundary one bit later
            if (w_slip) begin
               if (r_slip_cnt == CNT_W'(WIDTH - 1))
                  r_slip_cnt <= '0;
               else
                  r_slip_cnt <= r_slip_cnt + 1'b1;
            end else if (r_bcnt == CNT_W'(WIDTH - 1)) begin
               r_q     <= {r_sr, data_in};
               r_valid <= 1'b1;
               r_bcnt  <= '0;
            end else begin
               r_bcnt <= r_bcnt + 1'b1;
            end
         end
      end
   end

   assign Q          = r_q;
   assign DATA_VALID = r_valid;
   assign SLIP_CNT   = r_slip_cnt;

endmodule

`default_nettype wire

// File: tb/tb_i_serdes_deser_param.sv
// ============================================================================
// Module   : tb_i_serdes_deser_param
// Brief    : Directed self-checking bench for i_serdes_deser_param at WIDTH=4;
//            aligner scenarios run when I_SERDES_AUTO_ALIGN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i_serdes_deser_param;

   logic       CLK_IN = 1'b0;
   logic       RX_RST;
   logic       EN;
   logic       PLL_LOCK;
   logic       data_in;
   logic       BITSLIP_ADJ;
   logic [3:0] Q;
   logic       DATA_VALID;
   logic [1:0] SLIP_CNT;
   logic       ALIGN_LOCK;
   logic       ALIGN_ERROR;

   int         n_checks = 0;
   int         n_fails  = 0;
   logic [3:0] pat;
   int         ph;
   logic       dv_seen;

   always #5 CLK_IN = ~CLK_IN;

   i_serdes_deser_param #(
      .WIDTH         (4),
      .TRAIN_PATTERN (4'b0011),
      .LOCK_COUNT    (4)
   ) u_dut (
      .CLK_IN      (CLK_IN),
      .RX_RST      (RX_RST),
      .EN          (EN),
      .PLL_LOCK    (PLL_LOCK),
      .data_in     (data_in),
      .BITSLIP_ADJ (BITSLIP_ADJ),
      .Q           (Q),
      .DATA_VALID  (DATA_VALID),
      .SLIP_CNT    (SLIP_CNT),
      .ALIGN_LOCK  (ALIGN_LOCK),
      .ALIGN_ERROR (ALIGN_ERROR)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tx(input logic d, input logic slip);
      data_in     = d;
      BITSLIP_ADJ = slip;
      @(posedge CLK_IN);
      #1;
      if (DATA_VALID === 1'b1) dv_seen = 1'b1;
   endtask

   // next bit of the repeating pattern, MSB first
   task automatic txp(input logic slip);
      tx(pat[3-ph], slip);
      ph = (ph + 1) % 4;
   endtask

   task automatic word(input string tag, input int n, input int slip_at, input logic [3:0] exp_q);
      dv_seen = 1'b0;
      for (int i = 0; i < n - 1; i++) txp(i == slip_at);
      chk({tag, "_early"}, dv_seen, 0);
      txp(1'b0);
      chk({tag, "_dv"}, DATA_VALID, 1);
      chk({tag, "_q"}, Q, exp_q);
   endtask

   initial begin
      RX_RST = 1'b0; EN = 1'b0; PLL_LOCK = 1'b0; data_in = 1'b0; BITSLIP_ADJ = 1'b0;
      pat = 4'b0000; ph = 0; dv_seen = 1'b0;
      repeat (2) @(posedge CLK_IN);
      #1;
      chk("rst_q", Q, 0);
      chk("rst_dv", DATA_VALID, 0);
      chk("rst_sc", SLIP_CNT, 0);
      chk("rst_al", ALIGN_LOCK, 0);
      chk("rst_ae", ALIGN_ERROR, 0);
      RX_RST = 1'b1; EN = 1'b1; PLL_LOCK = 1'b1;

`ifdef I_SERDES_AUTO_ALIGN_EN
      begin
         int lock_tick;
         int err_tick;
         // pattern 0011 entering two bits late: first word is 1100
         pat = 4'b0011; ph = 2; lock_tick = -1;
         for (int t = 1; t <= 60 && lock_tick < 0; t++) begin
            txp(1'b0);
            if (ALIGN_LOCK === 1'b1) lock_tick = t;
         end
         chk("al_tick", lock_tick, 35);
         chk("al_sc", SLIP_CNT, 2);
         chk("al_q", Q, 4'b0011);
         chk("al_ae", ALIGN_ERROR, 0);
         txp(1'b1);
         chk("al_ext_sc", SLIP_CNT, 3);
         for (int i = 0; i < 8; i++) txp(1'b0);
         chk("al_hold", ALIGN_LOCK, 1);

         #2 RX_RST = 1'b0;
         #1;
         chk("mr_q", Q, 0);
         chk("mr_dv", DATA_VALID, 0);
         chk("mr_sc", SLIP_CNT, 0);
         chk("mr_al", ALIGN_LOCK, 0);
         @(posedge CLK_IN);
         #1 RX_RST = 1'b1;

         pat = 4'b0000; ph = 0; err_tick = -1;
         for (int t = 1; t <= 80 && err_tick < 0; t++) begin
            txp(1'b0);
            if (t == 25) chk("er_sc25", SLIP_CNT, 3);
            if (ALIGN_ERROR === 1'b1) err_tick = t;
         end
         chk("er_tick", err_tick, 41);
         chk("er_sc", SLIP_CNT, 0);
         chk("er_al", ALIGN_LOCK, 0);
         PLL_LOCK = 1'b0;
         tx(1'b0, 1'b0);
         PLL_LOCK = 1'b1;
         chk("er_clr", ALIGN_ERROR, 0);
      end
`else
      pat = 4'b1011; ph = 0;
      word("cap1", 4, -1, 4'b1011);
      word("cap2", 4, -1, 4'b1011);
      word("cap3", 4, -1, 4'b1011);

      pat = 4'b1000; ph = 0;
      word("bs0", 4, -1, 4'b1000);
      word("bs1", 5, 0, 4'b0001);
      chk("bs1_sc", SLIP_CNT, 1);

      #2 RX_RST = 1'b0;
      #1;
      chk("mr_q", Q, 0);
      chk("mr_dv", DATA_VALID, 0);
      chk("mr_sc", SLIP_CNT, 0);
      chk("mr_al", ALIGN_LOCK, 0);
      chk("mr_ae", ALIGN_ERROR, 0);
      @(posedge CLK_IN);
      #1 RX_RST = 1'b1;
      ph = 0;

      word("bs4_0", 4, -1, 4'b1000);
      word("bs4_1", 5, 0, 4'b0001);
      chk("bs4_1_sc", SLIP_CNT, 1);
      word("bs4_2", 5, 0, 4'b0010);
      chk("bs4_2_sc", SLIP_CNT, 2);
      word("bs4_3", 5, 0, 4'b0100);
      chk("bs4_3_sc", SLIP_CNT, 3);
      word("bs4_4", 5, 0, 4'b1000);
      chk("bs4_4_sc", SLIP_CNT, 0);
      word("bs_late", 5, 3, 4'b0001);
      chk("bs_late_sc", SLIP_CNT, 1);

      // two bits in, then a three-cycle EN gap carrying junk and a slip pulse
      dv_seen = 1'b0;
      txp(1'b0);
      txp(1'b0);
      EN = 1'b0;
      tx(1'b1, 1'b0);
      tx(1'b0, 1'b1);
      tx(1'b1, 1'b0);
      EN = 1'b1;
      chk("gate_nodv", dv_seen, 0);
      word("gate", 2, -1, 4'b0001);
      chk("gate_sc", SLIP_CNT, 1);

      txp(1'b0);
      txp(1'b0);
      PLL_LOCK = 1'b0;
      tx(1'b1, 1'b0);
      PLL_LOCK = 1'b1;
      chk("pll_q_hold", Q, 4'b0001);
      chk("pll_sc_hold", SLIP_CNT, 1);
      word("pll", 4, -1, 4'b0100);
      chk("tie_al", ALIGN_LOCK, 0);
      chk("tie_ae", ALIGN_ERROR, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
